// File: rtl/imem_responder_if.sv
// Fetch-side request/response handshake between the fetch stage and imem_responder.
interface imem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic [1:0]  rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency synchronous array read feeding a
// show-ahead response queue, with misaligned/out-of-range flagging and a program-load port.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  imem_responder_if.slave bus,
  input  logic            prog_we,
  input  logic [31:0]     prog_addr,
  input  logic [31:0]     prog_wdata,
  output logic            busy
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned FD = LATENCY + 1;
  localparam int unsigned PW = $clog2(FD);
  localparam int unsigned OW = $clog2(FD + 1);
  localparam logic [31:0]   NOP      = 32'h0000_0013;
  localparam logic [OW-1:0] FD_C     = OW'(FD);
  localparam logic [PW-1:0] LAST_PTR = PW'(FD - 1);

  function automatic logic [1:0] addr_err(input logic [31:0] addr);
    logic [1:0] e;
    e[0] = (addr[1:0] != 2'b00);
    e[1] = |addr[31:AW+2];
    return e;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == LAST_PTR) n = {PW{1'b0}};
    else               n = p + PW'(1'b1);
    return n;
  endfunction

  logic [31:0]   mem_r [DEPTH_WORDS];
  logic [OW-1:0] occ_r, occ_next_s;
  logic [OW-1:0] cnt_r, cnt_next_s;
  logic [PW-1:0] wptr_r, rptr_r;
  logic [31:0]   fifo_instr_r [FD];
  logic [31:0]   fifo_addr_r  [FD];
  logic [1:0]    fifo_err_r   [FD];

  logic          req_ready_s, accept_s, pull_s, rsp_valid_s;
  logic [1:0]    req_err_s, prog_err_s;
  logic [AW-1:0] req_idx_s;
  logic          push_valid_s;
  logic [31:0]   push_addr_s, push_data_s, push_instr_s;
  logic [1:0]    push_err_s;
  logic          unused_prog_lsb_s;

  assign req_err_s   = addr_err(bus.req_addr);
  assign req_idx_s   = bus.req_addr[AW+1:2];
  assign prog_err_s  = addr_err(prog_addr);
  // byte-lane bits of the program address carry no meaning for word writes
  assign unused_prog_lsb_s = prog_err_s[0];
  assign req_ready_s = reset && !prog_we && (occ_r < FD_C);
  assign accept_s    = bus.req_valid && req_ready_s;
  assign rsp_valid_s = (cnt_r != {OW{1'b0}});
  assign pull_s      = rsp_valid_s && bus.rsp_ready;

  // Program-load write port; array contents survive reset
  always_ff @(posedge clk) begin
    if (prog_we && (prog_err_s[1] == 1'b0)) mem_r[prog_addr[AW+1:2]] <= prog_wdata;
  end

  if (LATENCY == 1) begin : g_direct
    assign push_valid_s = accept_s;
    assign push_addr_s  = bus.req_addr;
    assign push_err_s   = req_err_s;
    assign push_data_s  = mem_r[req_idx_s];
  end else begin : g_pipe
    localparam int unsigned NS = LATENCY - 1;
    logic [NS-1:0] stg_valid_r;
    logic [31:0]   stg_addr_r [NS];
    logic [1:0]    stg_err_r  [NS];
    logic [31:0]   stg_data_r [NS];

    // Request pipeline; stage 0 captures the synchronous array read at accept
    always_ff @(posedge clk) begin
      if (!reset) stg_valid_r <= {NS{1'b0}};
      else begin
        stg_valid_r[0] <= accept_s;
        for (int k = 1; k < NS; k++) stg_valid_r[k] <= stg_valid_r[k-1];
      end
      stg_addr_r[0] <= bus.req_addr;
      stg_err_r[0]  <= req_err_s;
      stg_data_r[0] <= mem_r[req_idx_s];
      for (int k = 1; k < NS; k++) begin
        stg_addr_r[k] <= stg_addr_r[k-1];
        stg_err_r[k]  <= stg_err_r[k-1];
        stg_data_r[k] <= stg_data_r[k-1];
      end
    end

    assign push_valid_s = stg_valid_r[NS-1];
    assign push_addr_s  = stg_addr_r[NS-1];
    assign push_err_s   = stg_err_r[NS-1];
    assign push_data_s  = stg_data_r[NS-1];
  end

  // Faulty fetches never expose array content
  always_comb begin
    push_instr_s = push_data_s;
    if (push_err_s != 2'b00) push_instr_s = NOP;
    else                     push_instr_s = push_data_s;
  end

  // Occupancy (in flight + queued) and queue fill level next-state
  always_comb begin
    occ_next_s = occ_r;
    cnt_next_s = cnt_r;
    case ({accept_s, pull_s})
      2'b10:   occ_next_s = occ_r + OW'(1'b1);
      2'b01:   occ_next_s = occ_r - OW'(1'b1);
      default: occ_next_s = occ_r;
    endcase
    case ({push_valid_s, pull_s})
      2'b10:   cnt_next_s = cnt_r + OW'(1'b1);
      2'b01:   cnt_next_s = cnt_r - OW'(1'b1);
      default: cnt_next_s = cnt_r;
    endcase
  end

  // Response queue pointers, counters and storage
  always_ff @(posedge clk) begin
    if (!reset) begin
      occ_r  <= {OW{1'b0}};
      cnt_r  <= {OW{1'b0}};
      wptr_r <= {PW{1'b0}};
      rptr_r <= {PW{1'b0}};
    end else begin
      occ_r <= occ_next_s;
      cnt_r <= cnt_next_s;
      if (push_valid_s) wptr_r <= ptr_inc(wptr_r);
      if (pull_s)       rptr_r <= ptr_inc(rptr_r);
    end
    if (push_valid_s) begin
      fifo_instr_r[wptr_r] <= push_instr_s;
      fifo_addr_r[wptr_r]  <= push_addr_s;
      fifo_err_r[wptr_r]   <= push_err_s;
    end
  end

  // Show-ahead head of queue; idle value is a NOP at address 0
  always_comb begin
    bus.rsp_instr = NOP;
    bus.rsp_addr  = 32'h0000_0000;
    bus.rsp_err   = 2'b00;
    if (rsp_valid_s) begin
      bus.rsp_instr = fifo_instr_r[rptr_r];
      bus.rsp_addr  = fifo_addr_r[rptr_r];
      bus.rsp_err   = fifo_err_r[rptr_r];
    end else begin
      bus.rsp_instr = NOP;
      bus.rsp_addr  = 32'h0000_0000;
      bus.rsp_err   = 2'b00;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_s;
  assign busy          = (occ_r != {OW{1'b0}});
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (LATENCY 1, 2, 4) share stimulus and are
// checked each cycle against a transaction-level queue model plus directed vectors.
module tb_imem_responder;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid, rsp_ready, prog_we;
  logic [31:0] req_addr, prog_addr, prog_wdata;
  int checks = 0;
  int errors = 0;

  imem_responder_if bus_a ();
  imem_responder_if bus_b ();
  imem_responder_if bus_c ();
  logic busy_a, busy_b, busy_c;

  assign bus_a.req_valid = req_valid;
  assign bus_a.req_addr  = req_addr;
  assign bus_a.rsp_ready = rsp_ready;
  assign bus_b.req_valid = req_valid;
  assign bus_b.req_addr  = req_addr;
  assign bus_b.rsp_ready = rsp_ready;
  assign bus_c.req_valid = req_valid;
  assign bus_c.req_addr  = req_addr;
  assign bus_c.rsp_ready = rsp_ready;

  imem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .busy(busy_a));
  imem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .busy(busy_b));
  imem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .busy(busy_c));

  logic        o_ready [3];
  logic        o_valid [3];
  logic        o_busy  [3];
  logic [31:0] o_instr [3];
  logic [31:0] o_addr  [3];
  logic [1:0]  o_err   [3];
  assign o_ready[0] = bus_a.req_ready;
  assign o_ready[1] = bus_b.req_ready;
  assign o_ready[2] = bus_c.req_ready;
  assign o_valid[0] = bus_a.rsp_valid;
  assign o_valid[1] = bus_b.rsp_valid;
  assign o_valid[2] = bus_c.rsp_valid;
  assign o_busy[0]  = busy_a;
  assign o_busy[1]  = busy_b;
  assign o_busy[2]  = busy_c;
  assign o_instr[0] = bus_a.rsp_instr;
  assign o_instr[1] = bus_b.rsp_instr;
  assign o_instr[2] = bus_c.rsp_instr;
  assign o_addr[0]  = bus_a.rsp_addr;
  assign o_addr[1]  = bus_b.rsp_addr;
  assign o_addr[2]  = bus_c.rsp_addr;
  assign o_err[0]   = bus_a.rsp_err;
  assign o_err[1]   = bus_b.rsp_err;
  assign o_err[2]   = bus_c.rsp_err;

  // Reference model: one ordered list of outstanding fetches per instance, each
  // tagged with the cycle from which it becomes visible.
  logic [31:0] mem_m [256];
  logic [31:0] q_addr  [3][16];
  logic [31:0] q_instr [3][16];
  logic [1:0]  q_err   [3][16];
  int          q_due   [3][16];
  int          head [3];
  int          tail [3];
  int          cyc;
  bit          after_reset;

  bit tracking;
  int tcnt;
  int first_v [3];
  int last_v  [3];
  int vcnt    [3];
  int acc_dut [3];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  function automatic bit exp_ready(input int i);
    return reset && !prog_we && ((tail[i] - head[i]) < lat_of(i) + 1);
  endfunction

  function automatic bit exp_valid(input int i);
    return (tail[i] != head[i]) && (q_due[i][head[i] % 16] <= cyc);
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (LATENCY=%0d): got %h, expected %h", name, lat_of(i), act, exp);
    end
  endtask

  // One clock: compare all instances against the model, then advance the model over the edge.
  task automatic step();
    bit acc [3];
    bit pl  [3];
    int k;
    logic [1:0] e;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("req_ready", i, 32'(o_ready[i]), 32'(exp_ready(i)));
      chk("rsp_valid", i, 32'(o_valid[i]), 32'(exp_valid(i)));
      chk("busy", i, 32'(o_busy[i]), 32'(tail[i] != head[i]));
      if (exp_valid(i)) begin
        k = head[i] % 16;
        chk("rsp_instr", i, o_instr[i], q_instr[i][k]);
        chk("rsp_addr", i, o_addr[i], q_addr[i][k]);
        chk("rsp_err", i, 32'(o_err[i]), 32'(q_err[i][k]));
      end else if (after_reset) begin
        chk("idle_instr", i, o_instr[i], NOP);
        chk("idle_addr", i, o_addr[i], 32'h0);
        chk("idle_err", i, 32'(o_err[i]), 32'h0);
      end
      if (tracking && o_valid[i]) begin
        if (first_v[i] < 0) first_v[i] = tcnt;
        last_v[i] = tcnt;
        vcnt[i]++;
      end
      if (req_valid && o_ready[i]) acc_dut[i]++;
      acc[i] = req_valid && exp_ready(i);
      pl[i]  = exp_valid(i) && rsp_ready;
    end
    @(posedge clk);
    e[0] = (req_addr % 4) != 0;
    e[1] = (req_addr / 4) >= 256;
    for (int i = 0; i < 3; i++) begin
      if (!reset) head[i] = tail[i];
      else begin
        if (pl[i]) head[i]++;
        if (acc[i]) begin
          k = tail[i] % 16;
          q_addr[i][k]  = req_addr;
          q_err[i][k]   = e;
          q_instr[i][k] = (e != 2'b00) ? NOP : mem_m[req_addr[9:2]];
          q_due[i][k]   = cyc + lat_of(i);
          tail[i]++;
        end
      end
    end
    after_reset = !reset;
    if (prog_we && (prog_addr / 4) < 256) mem_m[prog_addr[9:2]] = prog_wdata;
    cyc++;
    tcnt++;
    @(negedge clk);
  endtask

  task automatic wait_b_valid(input string name);
    for (int k = 0; k < 10 && !o_valid[1]; k++) step();
    if (!o_valid[1]) begin
      checks++;
      errors++;
      $display("FAIL %s: no response within 10 cycles, rsp_valid=%b, required 1", name, o_valid[1]);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  err;
    logic [31:0] instr;
  } vec_t;

  vec_t        vt [8];
  logic [31:0] boot [4];

  initial begin
    vt[0] = '{32'h0000_0000, 2'b00, 32'h0050_0093};
    vt[1] = '{32'h0000_0004, 2'b00, 32'h00a0_0113};
    vt[2] = '{32'h0000_0008, 2'b00, 32'h0020_81b3};
    vt[3] = '{32'h0000_000C, 2'b00, 32'h0000_006f};
    vt[4] = '{32'h0000_0006, 2'b01, 32'h0000_0013};
    vt[5] = '{32'h0000_0400, 2'b10, 32'h0000_0013};
    vt[6] = '{32'h0000_03FC, 2'b00, 32'h1000_00FF};
    vt[7] = '{32'hFFFF_FFFF, 2'b11, 32'h0000_0013};
    boot[0] = 32'h0050_0093;
    boot[1] = 32'h00a0_0113;
    boot[2] = 32'h0020_81b3;
    boot[3] = 32'h0000_006f;

    reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; prog_we = 1'b0;
    req_addr = 32'h0; prog_addr = 32'h0; prog_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      head[i] = 0; tail[i] = 0; acc_dut[i] = 0; first_v[i] = -1; last_v[i] = -1; vcnt[i] = 0;
    end
    for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
    cyc = 0; tcnt = 0; tracking = 1'b0; after_reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    repeat (2) step();

    // Program load while still checking that prog_we holds off fetches
    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      prog_we = 1'b1;
      prog_addr = 32'(i * 4);
      prog_wdata = (i < 4) ? boot[i] : 32'h1000_0000 + 32'(i);
      step();
    end
    prog_we = 1'b0;

    // Directed vectors against fixed expectations (LATENCY=2 instance)
    rsp_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      req_valid = 1'b1;
      req_addr = vt[v].addr;
      step();
      req_valid = 1'b0;
      wait_b_valid("vec_rsp");
      chk("vec_instr", 1, o_instr[1], vt[v].instr);
      chk("vec_err", 1, 32'(o_err[1]), 32'(vt[v].err));
      chk("vec_addr", 1, o_addr[1], vt[v].addr);
      repeat (5) step();
    end

    // Back-to-back fetch of words 0..3: latency and throughput per instance
    tracking = 1'b1; tcnt = 0;
    for (int i = 0; i < 3; i++) begin first_v[i] = -1; last_v[i] = -1; vcnt[i] = 0; end
    for (int a = 0; a < 4; a++) begin
      req_valid = 1'b1;
      req_addr = 32'(a * 4);
      step();
    end
    req_valid = 1'b0;
    repeat (8) step();
    tracking = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("first_rsp_cycle", i, 32'(first_v[i]), 32'(lat_of(i)));
      chk("last_rsp_cycle", i, 32'(last_v[i]), 32'(lat_of(i) + 3));
      chk("rsp_count", i, 32'(vcnt[i]), 32'd4);
    end

    // Backpressure: exactly LATENCY+1 accepts with the fetch side stalled
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) acc_dut[i] = 0;
    for (int a = 0; a < 8; a++) begin
      req_valid = 1'b1;
      req_addr = 32'(a * 4);
      step();
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("full_accepts", i, 32'(acc_dut[i]), 32'(lat_of(i) + 1));
      chk("full_ready", i, 32'(o_ready[i]), 32'h0);
      chk("full_busy", i, 32'(o_busy[i]), 32'h1);
    end
    rsp_ready = 1'b1;
    repeat (12) step();
    req_valid = 1'b0;
    repeat (8) step();

    // Program write blocks acceptance; later fetch sees the new word
    req_valid = 1'b1; req_addr = 32'h10;
    prog_we = 1'b1; prog_addr = 32'h10; prog_wdata = 32'hCAFE_0001;
    #1;
    for (int i = 0; i < 3; i++) chk("prog_blocks_ready", i, 32'(o_ready[i]), 32'h0);
    step();
    prog_we = 1'b0;
    step();
    req_valid = 1'b0;
    wait_b_valid("prog_rsp");
    chk("prog_new_word", 1, o_instr[1], 32'hCAFE_0001);
    repeat (6) step();

    // Reset with entries queued discards them; array content survives
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
    repeat (3) step();
    req_valid = 1'b0;
    reset = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("rst_rsp_valid", i, 32'(o_valid[i]), 32'h0);
      chk("rst_busy", i, 32'(o_busy[i]), 32'h0);
      chk("rst_instr", i, o_instr[i], 32'h0000_0013);
    end
    reset = 1'b1; rsp_ready = 1'b1;
    step();
    req_valid = 1'b1; req_addr = 32'h0;
    step();
    req_valid = 1'b0;
    wait_b_valid("post_reset_rsp");
    chk("post_reset_mem0", 1, o_instr[1], 32'h0050_0093);
    repeat (6) step();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 7));
      req_valid = ($urandom_range(0, 3) != 0);
      if (r == 0)      req_addr = $urandom;
      else if (r == 1) req_addr = $urandom_range(0, 1023) | 32'h1;
      else             req_addr = $urandom_range(0, 255) * 4;
      rsp_ready  = ($urandom_range(0, 2) != 0);
      prog_we    = ($urandom_range(0, 15) == 0);
      prog_addr  = $urandom_range(0, 2047);
      prog_wdata = $urandom;
      reset      = ($urandom_range(0, 199) != 0);
      step();
    end
    reset = 1'b1; req_valid = 1'b0; prog_we = 1'b0; rsp_ready = 1'b1;
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
